cbus_rr_arbiter: RTL
====================

Name: cbus_rr_arbiter

Overview:
- Shares the single cache-bus (cbus) master port between several cache-side requesters (ICache, DCache cached refill/writeback, DCache uncached).
- Grants whole transactions round-robin and holds the grant from the first beat until the beat carrying `cresp.last`.
- Sits between the cache level and the memory/AXI bridge. Each requester sees a private cbus whose protocol is unchanged.

Parameters:
- NUM_REQ, 2, number of requester ports (must be ≥2).
- ID_BITS, $clog2(NUM_REQ), width of the owner index.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, asynchronous, active-low (asserted when 0).
- ireqs  in  cbus_req_t[NUM_REQ]  requests from each requester.
- iresps  out  cbus_resp_t[NUM_REQ]  responses routed back to each requester.
- oreq  out  cbus_req_t  request to the memory side.
- oresp  in  cbus_resp_t  response from the memory side.
- owner  out  ID_BITS  index of the current grant holder; valid only while busy.
- busy  out  1  a transaction is in progress.

Behaviour:
- Reset is asynchronous and active-low, so any register clears immediately when reset=0. Registers and their reset values:
  - state=IDLE
  - owner=0
  - last_grant=NUM_REQ-1, so requester 0 wins first.
- Outputs during reset: oreq='0, every iresps[i]='0, busy=0.
- States:
  - IDLE:
    - oreq='0 and all iresps='0.
    - If any ireqs[i].valid: pick the winner as the first valid index scanning last_grant+1, last_grant+2, … modulo NUM_REQ.
    - Next cycle: owner<=winner, state<=BUSY.
    - No valid request: stay IDLE.
  - BUSY:
    - oreq=ireqs[owner], passed through combinationally.
    - iresps[owner]=oresp; all other iresps='0.
    - On oresp.ready && oresp.last: state<=IDLE, last_grant<=owner.
- Latency: exactly one arbitration bubble cycle. A request first seen valid in IDLE appears on oreq in the following cycle.
- A requester is never granted twice in a row while another requester is waiting.
- Back-to-back operation:
  - The cycle after last, the arbiter is in IDLE and re-arbitrates.
  - The next grant goes to the next waiting index after the old owner.
  - The old owner may win again only if it is the only requester with valid set.
- Simultaneous requests: resolved by the round-robin pointer only, never by index order (except under the optional feature below).
- Owner drops valid mid-burst (protocol violation): oreq.valid follows it to 0 and the grant is held until a last beat arrives. There is no timeout.
- Non-owner requests:
  - Never see ready or last.
  - Must keep valid and payload stable until served, per cbus rules.
- oresp.ready/last while IDLE: ignored and not forwarded.
- Reset asserted mid-burst: the arbiter drops to IDLE immediately and the memory side is expected to be reset together with it.
- NUM_REQ need not be a power of two. Pointer arithmetic wraps explicitly at NUM_REQ-1 → 0.

Optional Feature:
- Macro: CBUS_ARB_FIXED_PRIO_EN.
- When defined:
  - Requester NUM_REQ-1 (the uncached/MMIO path) wins whenever it is valid in IDLE.
  - The other requesters arbitrate round-robin among themselves.
  - last_grant is updated only on completion of a non-priority transaction.
  - An in-flight burst is never pre-empted.
- When undefined: pure round-robin over all NUM_REQ ports.

Decomposition:
- Shared package (common):
  - cbus_req_t and cbus_resp_t, already present.
  - arbiter state enum arb_state_t {IDLE, BUSY}.
- One sub-module, rr_pick:
  - Combinational.
  - Inputs: valid vector and last_grant.
  - Outputs: winner index and any_valid.
  - Reused later for the AXI read/write channel split.

Test Plan:
- Reset: hold reset=0 while ireqs[0].valid=1 → oreq.valid=0, busy=0; release → ireqs[0] reaches oreq 1 cycle later, owner=0.
- Single burst: ireqs[1] MLEN16 read; memory returns 16 ready beats, last on beat 16 → iresps[1] gets all 16 beats, iresps[0] stays 0; busy falls the cycle after last.
- Contention: ireqs[0] and ireqs[1] both valid from reset, each doing a 4-beat burst → grant order 0,1,0,1; one idle cycle between bursts.
- Starvation check: ireqs[0] re-asserts immediately after each completion while ireqs[1] is waiting → ireqs[1] is served next every time.
- Stray response: oresp.ready=1, last=1 while IDLE → no iresps activity, state stays IDLE.
- Optional feature with CBUS_ARB_FIXED_PRIO_EN and NUM_REQ=3: ireqs[0] mid-burst, ireqs[1] and ireqs[2] waiting → after ireqs[0] completes, ireqs[2] is granted, then ireqs[1].

Source files
------------

// File: rtl/cbus_rr_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// cbus_rr_arbiter_pkg
//
// Purpose : shared cache-bus (cbus) types for the cache level and the
//           memory-side arbiter.
//   cbus_req_t  : one request beat from a cache-side requester
//                 (valid, write flag, size, address, strobe, write data,
//                 burst length).
//   cbus_resp_t : one response beat from the memory side
//                 (ready, last, read data).
//   arb_state_t : arbiter FSM state {IDLE, BUSY}.
//   resp_done() : true on the beat that closes a transaction.
// -----------------------------------------------------------------------------
package cbus_rr_arbiter_pkg;

  localparam int CBUS_ADDR_W = 32;
  localparam int CBUS_DATA_W = 64;
  localparam int CBUS_STRB_W = CBUS_DATA_W / 8;

  // Bytes per beat, AXI-style encoding.
  typedef enum logic [2:0] {
    MSIZE1 = 3'd0,
    MSIZE2 = 3'd1,
    MSIZE4 = 3'd2,
    MSIZE8 = 3'd3
  } cbus_size_t;

  // Beats per burst minus one, AXI-style encoding.
  typedef enum logic [3:0] {
    MLEN1  = 4'd0,
    MLEN2  = 4'd1,
    MLEN4  = 4'd3,
    MLEN8  = 4'd7,
    MLEN16 = 4'd15
  } cbus_len_t;

  typedef struct packed {
    logic                   valid;
    logic                   is_write;
    cbus_size_t             size;
    logic [CBUS_ADDR_W-1:0] addr;
    logic [CBUS_STRB_W-1:0] strobe;
    logic [CBUS_DATA_W-1:0] data;
    cbus_len_t              len;
  } cbus_req_t;

  typedef struct packed {
    logic                   ready;
    logic                   last;
    logic [CBUS_DATA_W-1:0] data;
  } cbus_resp_t;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  // A transaction ends on the accepted beat that also carries last.
  function automatic logic resp_done(input cbus_resp_t resp);
    return resp.ready & resp.last;
  endfunction

endpackage

// File: rtl/cbus_rr_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
//
// Purpose : combinational round-robin selector. Scans valid starting at the
//           index just after last_grant, wrapping explicitly at NUM_REQ-1,
//           and returns the first set index. NUM_REQ need not be a power of
//           two.
// Ports   :
//   valid      in  [NUM_REQ-1:0]  per-requester request flags
//   last_grant in  [ID_BITS-1:0]  index served most recently
//   winner     out [ID_BITS-1:0]  selected index (0 when nothing is valid)
//   any_valid  out                at least one valid bit is set
// -----------------------------------------------------------------------------
module rr_pick #(
  parameter int NUM_REQ = 2,
  parameter int ID_BITS = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [ID_BITS-1:0] last_grant,
  output logic [ID_BITS-1:0] winner,
  output logic               any_valid
);

  localparam logic [ID_BITS-1:0] LAST_IDX = ID_BITS'(NUM_REQ - 1);

  logic [ID_BITS-1:0] scan_idx;

  // Walk the ring once, starting after last_grant, and keep the first hit.
  always_comb begin
    winner    = '0;
    any_valid = 1'b0;
    scan_idx  = last_grant;
    for (int k = 0; k < NUM_REQ; k++) begin
      // Explicit wrap so non-power-of-two ring sizes never index past the end.
      if (scan_idx >= LAST_IDX) begin
        scan_idx = '0;
      end else begin
        scan_idx = scan_idx + ID_BITS'(1);
      end
      if (valid[scan_idx] && !any_valid) begin
        winner    = scan_idx;
        any_valid = 1'b1;
      end else begin
        winner    = winner;
        any_valid = any_valid;
      end
    end
  end

endmodule

// File: rtl/cbus_rr_arbiter.sv
// -----------------------------------------------------------------------------
// cbus_rr_arbiter
//
// Purpose : shares one cbus master port between NUM_REQ cache-side
//           requesters. Whole transactions are granted round-robin; the grant
//           is held from the first beat until the accepted beat carrying
//           last. One idle arbitration cycle separates consecutive grants.
//
// Build option : CBUS_ARB_FIXED_PRIO_EN
//   When defined, requester NUM_REQ-1 (uncached/MMIO path) wins whenever it
//   is valid in IDLE; the remaining requesters share round-robin among
//   themselves and the pointer only moves on their completions. A burst in
//   flight is never pre-empted. Undefined: plain round-robin over all ports.
//
// Ports :
//   clk     in   clock
//   reset   in   asynchronous active-low reset
//   ireqs   in   cbus_req_t  [NUM_REQ]  requests from each requester
//   iresps  out  cbus_resp_t [NUM_REQ]  responses routed to each requester
//   oreq    out  cbus_req_t             request to the memory side
//   oresp   in   cbus_resp_t            response from the memory side
//   owner   out  [ID_BITS-1:0]          current grant holder (valid when busy)
//   busy    out                         a transaction is in progress
// -----------------------------------------------------------------------------
module cbus_rr_arbiter
  import cbus_rr_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ID_BITS = $clog2(NUM_REQ)
) (
  input  logic                clk,
  input  logic                reset,
  input  cbus_req_t           ireqs  [NUM_REQ],
  output cbus_resp_t          iresps [NUM_REQ],
  output cbus_req_t           oreq,
  input  cbus_resp_t          oresp,
  output logic [ID_BITS-1:0]  owner,
  output logic                busy
);

  localparam logic [ID_BITS-1:0] LAST_IDX = ID_BITS'(NUM_REQ - 1);

  arb_state_t         state_q,      state_d;
  logic [ID_BITS-1:0] owner_q,      owner_d;
  logic [ID_BITS-1:0] last_grant_q, last_grant_d;
  logic               busy_q,       busy_d;

  logic [NUM_REQ-1:0] req_valid_s;
  logic [NUM_REQ-1:0] pick_valid_s;
  logic [ID_BITS-1:0] rr_winner_s;
  logic               rr_any_s;
  logic [ID_BITS-1:0] grant_idx_s;
  logic               grant_any_s;
  logic               done_s;

  // Gather the per-port valid flags into a vector for the picker.
  always_comb begin
    req_valid_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_valid_s[i] = ireqs[i].valid;
    end
  end

`ifdef CBUS_ARB_FIXED_PRIO_EN
  // The priority port is kept out of the ring so the others rotate among
  // themselves undisturbed by MMIO traffic.
  always_comb begin
    pick_valid_s           = req_valid_s;
    pick_valid_s[NUM_REQ-1] = 1'b0;
  end

  // Priority port overrides the ring whenever it asks.
  always_comb begin
    if (req_valid_s[NUM_REQ-1]) begin
      grant_idx_s = LAST_IDX;
      grant_any_s = 1'b1;
    end else begin
      grant_idx_s = rr_winner_s;
      grant_any_s = rr_any_s;
    end
  end
`else
  // Every port takes part in the ring.
  always_comb begin
    pick_valid_s = req_valid_s;
  end

  // Winner comes straight from the ring.
  always_comb begin
    grant_idx_s = rr_winner_s;
    grant_any_s = rr_any_s;
  end
`endif

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_BITS (ID_BITS)
  ) u_rr_pick (
    .valid      (pick_valid_s),
    .last_grant (last_grant_q),
    .winner     (rr_winner_s),
    .any_valid  (rr_any_s)
  );

  assign done_s = resp_done(oresp);

  // Next-state logic: arbitrate in IDLE, hold the grant through BUSY.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    busy_d       = busy_q;
    case (state_q)
      IDLE: begin
        // Responses seen while idle are strays and are simply ignored.
        if (grant_any_s) begin
          state_d = BUSY;
          owner_d = grant_idx_s;
          busy_d  = 1'b1;
        end else begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      BUSY: begin
        // No timeout: a dropped valid still waits for the last beat.
        if (done_s) begin
          state_d = IDLE;
          busy_d  = 1'b0;
`ifdef CBUS_ARB_FIXED_PRIO_EN
          if (owner_q != LAST_IDX) begin
            last_grant_d = owner_q;
          end else begin
            last_grant_d = last_grant_q;
          end
`else
          last_grant_d = owner_q;
`endif
        end else begin
          state_d = BUSY;
          busy_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State, grant holder, ring pointer and busy flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      owner_q      <= '0;
      last_grant_q <= LAST_IDX;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      busy_q       <= busy_d;
    end
  end

  // Data path: the owner's request and the memory response pass straight
  // through while BUSY; everything is quiet otherwise.
  always_comb begin
    oreq = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      iresps[i] = '0;
    end
    if (state_q == BUSY) begin
      oreq = ireqs[owner_q];
      for (int i = 0; i < NUM_REQ; i++) begin
        if (owner_q == ID_BITS'(i)) begin
          iresps[i] = oresp;
        end else begin
          iresps[i] = '0;
        end
      end
    end else begin
      oreq = '0;
    end
  end

  assign owner = owner_q;
  assign busy  = busy_q;

endmodule
